branch_redirect_exwb: RTL and testbench

//  Producer side of the PC-redirect interface into the PC-select stage.

---
 rtl/branch_redirect_exwb.sv | 74 +++++++
 tb/tb_branch_redirect_exwb.sv | 119 +++++++++++
 2 files changed

// File: rtl/branch_redirect_exwb.sv
// branch_redirect_exwb: resolves EX jumps/branches into a registered redirect pulse,
// squashes the shadow slots behind a taken redirect, and counts taken redirects.
module branch_redirect_exwb #(
  parameter int PC_W   = 8,
  parameter int SHADOW = 2,
  parameter int CNT_W  = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             stall,
  input  logic             valid_IDEX,
  input  logic [1:0]       jumpType_IDEX,
  input  logic [PC_W-1:0]  PC_IDEX,
  input  logic [PC_W-1:0]  offset_IDEX,
  input  logic             zero_EX,
  output logic             jumpIns_EXWB,
  output logic [PC_W-1:0]  PCnew_EXWB,
  output logic             squash,
  output logic [CNT_W-1:0] redirect_cnt
);
  typedef enum logic {RUN, SQUASH} state_t;
  state_t state, state_n;
  logic [3:0] ctr, ctr_n;
  logic jump_n, squash_n, taken;
  logic [PC_W-1:0] pc_n, target;
  logic [CNT_W-1:0] cnt_n;
  assign taken = valid_IDEX && state == RUN &&
                 (jumpType_IDEX == 2'b01 || (jumpType_IDEX == 2'b10 && zero_EX) ||
                  (jumpType_IDEX == 2'b11 && !zero_EX));
  assign target = jumpType_IDEX == 2'b01 ? offset_IDEX : PC_IDEX + PC_W'(1) + offset_IDEX;
  always_comb begin
    state_n  = state;
    ctr_n    = ctr;
    jump_n   = jumpIns_EXWB;
    pc_n     = PCnew_EXWB;
    squash_n = squash;
    cnt_n    = redirect_cnt;
    if (!stall) begin
      jump_n = 1'b0;
      if (state == RUN) begin
        squash_n = taken;
        if (taken) begin
          jump_n  = 1'b1;
          pc_n    = target;
          ctr_n   = 4'(SHADOW - 1);
          cnt_n   = &redirect_cnt ? redirect_cnt : redirect_cnt + CNT_W'(1);
          state_n = SQUASH;
        end
      end else if (ctr == 4'd0) begin
        squash_n = 1'b0;
        state_n  = RUN;
      end else begin
        ctr_n = ctr - 4'd1;
      end
    end
  end
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state        <= RUN;
      ctr          <= '0;
      jumpIns_EXWB <= 1'b0;
      PCnew_EXWB   <= '0;
      squash       <= 1'b0;
      redirect_cnt <= '0;
    end else begin
      state        <= state_n;
      ctr          <= ctr_n;
      jumpIns_EXWB <= jump_n;
      PCnew_EXWB   <= pc_n;
      squash       <= squash_n;
      redirect_cnt <= cnt_n;
    end
  end
endmodule

// File: tb/tb_branch_redirect_exwb.sv
// tb_branch_redirect_exwb: directed scenarios with a queue of expected outputs,
// one entry pushed per driven cycle and popped after the following clock edge.
module tb_branch_redirect_exwb;
  logic clk = 1'b0;
  logic reset = 1'b0;
  logic stall = 1'b0;
  logic valid = 1'b0;
  logic [1:0] jt = 2'b00;
  logic [7:0] pc = '0, off = '0;
  logic zero = 1'b0;
  logic jump, sq, jump2, sq2;
  logic [7:0] pcnew, cnt, pcnew2;
  logic [1:0] cnt2;
  int checks = 0;
  int failures = 0;

  typedef struct packed {
    logic       j;
    logic [7:0] pc;
    logic       sq;
    logic [7:0] cnt;
    logic [1:0] cnt2;
  } exp_t;
  exp_t sb[$];

  always #5 clk = ~clk;

  branch_redirect_exwb #(.PC_W(8), .SHADOW(2), .CNT_W(8)) dut (
    .clk(clk), .reset(reset), .stall(stall), .valid_IDEX(valid), .jumpType_IDEX(jt),
    .PC_IDEX(pc), .offset_IDEX(off), .zero_EX(zero),
    .jumpIns_EXWB(jump), .PCnew_EXWB(pcnew), .squash(sq), .redirect_cnt(cnt)
  );

  branch_redirect_exwb #(.PC_W(8), .SHADOW(2), .CNT_W(2)) dut2 (
    .clk(clk), .reset(reset), .stall(stall), .valid_IDEX(valid), .jumpType_IDEX(jt),
    .PC_IDEX(pc), .offset_IDEX(off), .zero_EX(zero),
    .jumpIns_EXWB(jump2), .PCnew_EXWB(pcnew2), .squash(sq2), .redirect_cnt(cnt2)
  );

  task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
    checks++;
    assert (got === exp) else begin
      failures++;
      $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic compare(input string tag, input exp_t e);
    chk({tag, ".jump"}, {7'd0, jump}, {7'd0, e.j});
    chk({tag, ".pcnew"}, pcnew, e.pc);
    chk({tag, ".squash"}, {7'd0, sq}, {7'd0, e.sq});
    chk({tag, ".cnt"}, cnt, e.cnt);
    chk({tag, ".cnt2"}, {6'd0, cnt2}, {6'd0, e.cnt2});
  endtask

  // Drive one EX cycle, queue the outputs expected after the next edge, then check them.
  task automatic step(input string tag, input logic st, input logic v, input logic [1:0] t,
                      input logic [7:0] p, input logic [7:0] o, input logic z,
                      input logic ej, input logic [7:0] epc, input logic esq,
                      input logic [7:0] ecnt, input logic [1:0] ecnt2);
    stall = st; valid = v; jt = t; pc = p; off = o; zero = z;
    sb.push_back('{ej, epc, esq, ecnt, ecnt2});
    @(posedge clk);
    #1;
    compare(tag, sb.pop_front());
  endtask

  initial begin
    // reset held with random inputs
    for (int i = 0; i < 3; i++) begin
      valid = 1'(($urandom)); jt = 2'($urandom); pc = 8'($urandom);
      off = 8'($urandom); zero = 1'($urandom); stall = 1'($urandom);
      @(posedge clk);
      #1;
    end
    compare("reset", '{1'b0, 8'h00, 1'b0, 8'd0, 2'd0});
    reset = 1'b1;
    step("idle0", 0, 1, 2'b00, 8'h12, 8'h34, 1, 0, 8'h00, 0, 0, 0);
    // JMP absolute
    step("jmp40", 0, 1, 2'b01, 8'h00, 8'h40, 0, 1, 8'h40, 1, 1, 1);
    step("jmp40+1", 0, 0, 2'b00, 8'h00, 8'h00, 0, 0, 8'h40, 1, 1, 1);
    step("jmp40+2", 0, 0, 2'b00, 8'h00, 8'h00, 0, 0, 8'h40, 0, 1, 1);
    step("jmp40+3", 0, 0, 2'b00, 8'h00, 8'h00, 0, 0, 8'h40, 0, 1, 1);
    // BEQ with wrap, then not taken
    step("beq_wrap", 0, 1, 2'b10, 8'hFE, 8'h05, 1, 1, 8'h04, 1, 2, 2);
    step("beq+1", 0, 0, 2'b00, 8'h00, 8'h00, 0, 0, 8'h04, 1, 2, 2);
    step("beq+2", 0, 0, 2'b00, 8'h00, 8'h00, 0, 0, 8'h04, 0, 2, 2);
    step("beq_nt", 0, 1, 2'b10, 8'hFE, 8'h05, 0, 0, 8'h04, 0, 2, 2);
    step("beq_invalid", 0, 0, 2'b01, 8'h00, 8'h99, 0, 0, 8'h04, 0, 2, 2);
    // BNE taken, JMPs in both shadow slots ignored, JMP after exit resolves
    step("bne", 0, 1, 2'b11, 8'h10, 8'h03, 0, 1, 8'h14, 1, 3, 3);
    step("shadow1", 0, 1, 2'b01, 8'h00, 8'h80, 0, 0, 8'h14, 1, 3, 3);
    step("shadow2", 0, 1, 2'b01, 8'h00, 8'h80, 0, 0, 8'h14, 0, 3, 3);
    step("post_jmp", 0, 1, 2'b01, 8'h00, 8'h80, 0, 1, 8'h80, 1, 4, 3);
    step("post+1", 0, 0, 2'b00, 8'h00, 8'h00, 0, 0, 8'h80, 1, 4, 3);
    step("post+2", 0, 0, 2'b00, 8'h00, 8'h00, 0, 0, 8'h80, 0, 4, 3);
    // stall holds the pulse and squash
    step("jmp22", 0, 1, 2'b01, 8'h00, 8'h22, 0, 1, 8'h22, 1, 5, 3);
    for (int i = 0; i < 3; i++)
      step("stall", 1, 1, 2'b01, 8'h00, 8'h77, 0, 1, 8'h22, 1, 5, 3);
    step("unstall+1", 0, 0, 2'b00, 8'h00, 8'h00, 0, 0, 8'h22, 1, 5, 3);
    step("unstall+2", 0, 0, 2'b00, 8'h00, 8'h00, 0, 0, 8'h22, 0, 5, 3);
    // BNE wrapping to FF, then reset mid-squash
    step("bne_wrap", 0, 1, 2'b11, 8'h02, 8'hFC, 0, 1, 8'hFF, 1, 6, 3);
    step("bne_wrap+1", 0, 0, 2'b00, 8'h00, 8'h00, 0, 0, 8'hFF, 1, 6, 3);
    #2;
    reset = 1'b0;
    #1;
    compare("mid_reset", '{1'b0, 8'h00, 1'b0, 8'd0, 2'd0});
    @(posedge clk);
    #1;
    reset = 1'b1;
    step("after_reset", 0, 1, 2'b01, 8'h00, 8'h33, 0, 1, 8'h33, 1, 1, 1);
    step("after_reset+1", 0, 0, 2'b00, 8'h00, 8'h00, 0, 0, 8'h33, 1, 1, 1);
    step("after_reset+2", 0, 0, 2'b00, 8'h00, 8'h00, 0, 0, 8'h33, 0, 1, 1);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
